// File: rtl/lbp_pkg.sv
// Shared types and constants for the streaming LBP engine.
package lbp_pkg;

    typedef enum logic [2:0] {IDLE, PRIME, SHIFT, BORDER, DONE} state_t;

    localparam int unsigned B_TL = 0;
    localparam int unsigned B_T  = 1;
    localparam int unsigned B_TR = 2;
    localparam int unsigned B_L  = 3;
    localparam int unsigned B_R  = 4;
    localparam int unsigned B_BL = 5;
    localparam int unsigned B_B  = 6;
    localparam int unsigned B_BR = 7;

    function automatic int unsigned border_count(input int unsigned w, input int unsigned h);
        return 2 * w + 2 * (h - 2);
    endfunction

endpackage

// File: rtl/lbp_window.sv
// 3x3 pixel window loaded one column at a time, plus the 8-way threshold compare.
module lbp_window
    import lbp_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_shift,
    input  logic [1:0]    i_row,
    input  logic [DW-1:0] i_data,
    input  logic [DW-1:0] i_thr,
    output logic [7:0]    o_code
);

    // Indexed [column][row]; new pixels always land in column 2.
    logic [DW-1:0] r_win [3][3];
    logic [DW:0]   w_ref;
    logic [DW-1:0] w_nb [8];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned c = 0; c < 3; c++) begin
                for (int unsigned r = 0; r < 3; r++) begin
                    r_win[c][r] <= '0;
                end
            end
        end else if (i_load) begin
            if (i_shift) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
            end
            r_win[2][i_row] <= i_data;
        end
    end

    // Reference is one bit wider so center+thr overflow clears the bit.
    always_comb begin
        w_ref     = {1'b0, r_win[1][1]} + {1'b0, i_thr};
        w_nb[B_TL] = r_win[0][0];
        w_nb[B_T]  = r_win[1][0];
        w_nb[B_TR] = r_win[2][0];
        w_nb[B_L]  = r_win[0][1];
        w_nb[B_R]  = r_win[2][1];
        w_nb[B_BL] = r_win[0][2];
        w_nb[B_B]  = r_win[1][2];
        w_nb[B_BR] = r_win[2][2];
        o_code = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            o_code[i] = ({1'b0, w_nb[i]} >= w_ref);
        end
    end

endmodule

// File: rtl/lbp_stream.sv
// Streaming LBP engine: column-shifting window over a WxH image, then optional border clear.
module lbp_stream
    import lbp_pkg::*;
#(
    parameter int IMG_W        = 128,
    parameter int IMG_H        = 128,
    parameter int DW           = 8,
    parameter int AW           = $clog2(IMG_W * IMG_H),
    parameter int BORDER_WRITE = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          gray_ready,
    output logic [AW-1:0] gray_addr,
    output logic          gray_req,
    input  logic [DW-1:0] gray_data,
    input  logic [DW-1:0] thr,
    output logic [AW-1:0] lbp_addr,
    output logic          lbp_valid,
    output logic [7:0]    lbp_data,
    output logic          finish
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [AW-1:0] A_W     = AW'(IMG_W);
    localparam logic [AW-1:0] A_W2    = AW'(2 * IMG_W);
    localparam logic [AW-1:0] A_BSTEP = AW'(IMG_W - 1);
    localparam logic [AW-1:0] A_LROW  = AW'((IMG_H - 1) * IMG_W);
    localparam logic [AW-1:0] A_BLAST = AW'(border_count(IMG_W, IMG_H) - 1);

    state_t        r_state, w_next;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [AW-1:0] r_top;
    logic [1:0]    r_k, r_kc;
    logic          r_pend;
    logic [AW-1:0] r_lbp_addr;
    logic [AW-1:0] r_bcnt;
    logic          r_bside;
    logic [DW-1:0] r_thr;

    logic          w_rd, w_col_end, w_win_done, w_row_end, w_last_row, w_brow;
    logic [AW-1:0] w_row_ofs;
    logic [1:0]    w_col_ofs;
    logic [7:0]    w_code;

    lbp_window #(.DW(DW)) u_win (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_rd),
        .i_shift (r_k == 2'd0),
        .i_row   (r_k),
        .i_data  (gray_data),
        .i_thr   (r_thr),
        .o_code  (w_code)
    );

    always_comb begin
        w_rd       = ((r_state == PRIME) || (r_state == SHIFT)) && gray_ready;
        w_col_end  = w_rd && (r_k == 2'd2);
        w_win_done = w_col_end && ((r_state == SHIFT) || (r_kc == 2'd2));
        w_row_end  = w_win_done && (r_col == CW'(IMG_W - 2));
        w_last_row = (r_row == RW'(IMG_H - 2));
        w_brow     = (r_lbp_addr < A_W) || (r_lbp_addr >= A_LROW);
        w_row_ofs  = '0;
        case (r_k)
            2'd1:    w_row_ofs = A_W;
            2'd2:    w_row_ofs = A_W2;
            default: ;
        endcase
        w_col_ofs = (r_state == SHIFT) ? 2'd2 : r_kc;
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        gray_req  = w_rd;
        gray_addr = '0;
        lbp_valid = r_pend || (r_state == BORDER);
        lbp_data  = r_pend ? w_code : '0;
        lbp_addr  = r_lbp_addr;
        finish    = 1'b0;
        case (r_state)
            IDLE: if (gray_ready) w_next = PRIME;
            PRIME, SHIFT: begin
                gray_addr = r_top + w_row_ofs + AW'(w_col_ofs);
                if (w_row_end) begin
                    if (!w_last_row)            w_next = PRIME;
                    else if (BORDER_WRITE != 0) w_next = BORDER;
                    else                        w_next = DONE;
                end else if (w_win_done) begin
                    w_next = SHIFT;
                end
            end
            BORDER: if (!r_pend && (r_bcnt == A_BLAST)) w_next = DONE;
            DONE: begin
                // Let the last pixel's write drain before pulsing finish.
                if (!r_pend) begin
                    finish = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_row      <= '0;
            r_col      <= '0;
            r_top      <= '0;
            r_k        <= '0;
            r_kc       <= '0;
            r_pend     <= 1'b0;
            r_lbp_addr <= '0;
            r_bcnt     <= '0;
            r_bside    <= 1'b0;
            r_thr      <= '0;
        end else begin
            r_pend <= w_win_done;
            case (r_state)
                IDLE: if (gray_ready) begin
                    r_thr <= thr;
                    r_row <= RW'(1);
                    r_col <= CW'(1);
                    r_top <= '0;
                    r_k   <= '0;
                    r_kc  <= '0;
                end
                PRIME, SHIFT: if (w_rd) begin
                    r_k <= (r_k == 2'd2) ? 2'd0 : r_k + 2'd1;
                    if (w_col_end && (r_state == PRIME)) r_kc <= (r_kc == 2'd2) ? 2'd0 : r_kc + 2'd1;
                    if (w_win_done) begin
                        r_lbp_addr <= r_top + A_W + AW'(1);
                        if (!w_row_end) begin
                            r_col <= r_col + CW'(1);
                            r_top <= r_top + AW'(1);
                        end else if (!w_last_row) begin
                            r_row <= r_row + RW'(1);
                            r_col <= CW'(1);
                            r_top <= r_top + AW'(3);
                        end
                    end
                end
                BORDER: begin
                    // Interior rows alternate column 0 and column W-1.
                    if (r_pend) begin
                        r_lbp_addr <= '0;
                        r_bcnt     <= '0;
                        r_bside    <= 1'b0;
                    end else begin
                        r_bcnt <= r_bcnt + AW'(1);
                        if (w_brow || r_bside) begin
                            r_lbp_addr <= r_lbp_addr + AW'(1);
                            r_bside    <= 1'b0;
                        end else begin
                            r_lbp_addr <= r_lbp_addr + A_BSTEP;
                            r_bside    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_stream.sv
// Directed bench: 3x3 engine with border clear and 4x4 engine without, checked against hand-computed results.
module tb_lbp_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [1:0]       ready;
    logic [1:0][7:0]  thr_v;
    logic [1:0][3:0]  g_addr;
    logic [1:0]       g_req;
    logic [1:0][7:0]  g_data;
    logic [1:0][3:0]  l_addr;
    logic [1:0]       l_valid;
    logic [1:0][7:0]  l_data;
    logic [1:0]       fin;
    logic [7:0]       mem [2][16];

    assign g_data[0] = mem[0][g_addr[0]];
    assign g_data[1] = mem[1][g_addr[1]];

    lbp_stream #(.IMG_W(3), .IMG_H(3), .DW(8), .BORDER_WRITE(1)) u_a (
        .clk(clk), .reset(reset), .gray_ready(ready[0]), .gray_addr(g_addr[0]),
        .gray_req(g_req[0]), .gray_data(g_data[0]), .thr(thr_v[0]), .lbp_addr(l_addr[0]),
        .lbp_valid(l_valid[0]), .lbp_data(l_data[0]), .finish(fin[0])
    );

    lbp_stream #(.IMG_W(4), .IMG_H(4), .DW(8), .BORDER_WRITE(0)) u_b (
        .clk(clk), .reset(reset), .gray_ready(ready[1]), .gray_addr(g_addr[1]),
        .gray_req(g_req[1]), .gray_data(g_data[1]), .thr(thr_v[1]), .lbp_addr(l_addr[1]),
        .lbp_valid(l_valid[1]), .lbp_data(l_data[1]), .finish(fin[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_n[2], wr_n[2], fin_n[2], first_req[2], fin_cyc[2];
    int wr_addr[2][32], wr_data[2][32], wr_cyc[2][32];
    int img1[9]     = '{40, 50, 60, 49, 50, 51, 50, 10, 255};
    int exp_bord[8] = '{0, 1, 2, 3, 5, 6, 7, 8};
    int exp_b[4]    = '{5, 6, 9, 10};

    always begin
        @(negedge clk);
        #2;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (g_req[d] === 1'b1) begin
                if (rd_n[d] == 0) first_req[d] = cyc;
                rd_n[d]++;
            end
            if (l_valid[d] === 1'b1) begin
                if (wr_n[d] < 32) begin
                    wr_addr[d][wr_n[d]] = int'(l_addr[d]);
                    wr_data[d][wr_n[d]] = int'(l_data[d]);
                    wr_cyc[d][wr_n[d]]  = cyc;
                end
                wr_n[d]++;
            end
            if (fin[d] === 1'b1) begin
                fin_n[d]++;
                fin_cyc[d] = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log(input int d);
        rd_n[d] = 0; wr_n[d] = 0; fin_n[d] = 0; first_req[d] = 0; fin_cyc[d] = 0;
    endtask

    task automatic start(input int d);
        @(negedge clk);
        clear_log(d);
        ready[d] = 1'b1;
    endtask

    task automatic wait_finish(input int d, input int limit);
        int n = 0;
        while (fin_n[d] == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        ready[d] = 1'b0;
        chk($sformatf("finish_seen_%0d", d), 32'(fin_n[d] != 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_golden_b(input string pfx);
        chk({pfx, "_wr_count"}, wr_n[1], 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_addr%0d", pfx, i), wr_addr[1][i], exp_b[i]);
            chk($sformatf("%s_data%0d", pfx, i), wr_data[1][i], 32'hF0);
        end
        chk({pfx, "_reads"}, rd_n[1], 24);
        chk({pfx, "_finish_once"}, fin_n[1], 1);
    endtask

    initial begin
        reset = 1'b0;
        ready = '0;
        thr_v = '0;
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = '0;
            mem[1][i] = 8'(i);
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_gray_addr", g_addr[0], 0);
        chk("rst_gray_req", g_req[0], 0);
        chk("rst_lbp_addr", l_addr[0], 0);
        chk("rst_lbp_valid", l_valid[0], 0);
        chk("rst_lbp_data", l_data[0], 0);
        chk("rst_finish", fin[0], 0);
        chk("rst_b_req", g_req[1], 0);
        chk("rst_b_valid", l_valid[1], 0);
        chk("rst_b_finish", fin[1], 0);
        reset = 1'b1;

        // 3x3 bit-ordering frame with border clear
        for (int i = 0; i < 9; i++) mem[0][i] = 8'(img1[i]);
        thr_v[0] = 8'd0;
        start(0);
        wait_finish(0, 100);
        chk("a_wr_count", wr_n[0], 9);
        chk("a_center_addr", wr_addr[0][0], 4);
        chk("a_center_code", wr_data[0][0], 32'hB6);
        for (int i = 1; i < 9; i++) begin
            chk($sformatf("a_border_addr%0d", i), wr_addr[0][i], exp_bord[i-1]);
            chk($sformatf("a_border_data%0d", i), wr_data[0][i], 0);
        end
        chk("a_reads", rd_n[0], 9);
        chk("a_write_latency", wr_cyc[0][0] - first_req[0], 9);
        chk("a_border_continuous", wr_cyc[0][8] - wr_cyc[0][1], 7);
        chk("a_frame_cycles", fin_cyc[0] - first_req[0], 18);
        chk("a_finish_once", fin_n[0], 1);

        // center+thr overflows 8 bits: every bit clears
        for (int i = 0; i < 9; i++) mem[0][i] = 8'd255;
        mem[0][4] = 8'd250;
        thr_v[0] = 8'd10;
        start(0);
        wait_finish(0, 100);
        chk("sat_code", wr_data[0][0], 32'h00);
        chk("sat_wr_count", wr_n[0], 9);

        // equality sets the bit; thr changed mid-frame is ignored
        thr_v[0] = 8'd5;
        start(0);
        repeat (2) @(negedge clk);
        thr_v[0] = 8'd10;
        wait_finish(0, 100);
        chk("eq_code", wr_data[0][0], 32'hFF);

        // 4x4 ramp, no border pass
        thr_v[1] = 8'd0;
        start(1);
        wait_finish(1, 200);
        check_golden_b("ramp");
        chk("ramp_frame_cycles", fin_cyc[1] - first_req[1], 25);

        // 5-cycle stall at the first SHIFT read
        start(1);
        repeat (10) @(negedge clk);
        ready[1] = 1'b0;
        #1;
        chk("stall_req0", g_req[1], 0);
        chk("stall_addr0", g_addr[1], 3);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("stall_req%0d", i), g_req[1], 0);
            chk($sformatf("stall_addr%0d", i), g_addr[1], 3);
        end
        @(negedge clk);
        ready[1] = 1'b1;
        wait_finish(1, 200);
        check_golden_b("stall");
        chk("stall_frame_cycles", fin_cyc[1] - first_req[1], 30);

        // reset pulse during PRIME of row 2, then a clean rerun
        start(1);
        repeat (15) @(negedge clk);
        reset = 1'b0;
        ready[1] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mrst_gray_addr", g_addr[1], 0);
        chk("mrst_gray_req", g_req[1], 0);
        chk("mrst_lbp_addr", l_addr[1], 0);
        chk("mrst_lbp_valid", l_valid[1], 0);
        chk("mrst_lbp_data", l_data[1], 0);
        chk("mrst_finish", fin[1], 0);
        repeat (5) @(negedge clk);
        chk("mrst_no_finish", fin_n[1], 0);
        start(1);
        wait_finish(1, 200);
        check_golden_b("rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
